ram_tester: RTL and testbench

- Initiator (master) for the single-port synchronous RAM port (en/we/re, registered read data, 1-cycle read latency).
- On a start pulse it fills addresses 0..RAM_DEPTH-1 with a seeded pattern, reads them back, compares each word and reports pass/fail, error count and first failing address.
- Used for power-on memory check and as a reusable bus-driving front end for RAM instances.

---
 rtl/ram_tester_pkg.sv | 31 +++
 rtl/ram_tester.sv | 195 +++++++++++++++++++
 tb/tb_ram_tester.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_tester_pkg.sv
// Shared definitions for the RAM tester: state encoding and the test pattern generator.
package ram_tester_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = IDLE,
        StWrite = WRITE,
        StRead  = READ,
        StDrain = DRAIN,
        StDone  = DONE
    } state_e;

    // Widest word the pattern helper supports; callers truncate to their own width.
    localparam int unsigned PAT_W = 64;

    function automatic logic [PAT_W-1:0] pattern(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] k,
        input logic             mode
    );
        logic [PAT_W-1:0] sum;
        sum = seed + k;
        return mode ? ~sum : sum;
    endfunction

endpackage

// File: rtl/ram_tester.sv
// Write/read-back tester driving a single-port synchronous RAM with 1-cycle read latency.
module ram_tester
    import ram_tester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RAM_DEPTH  = 16
) (
    input  logic                  i_clk_rt,
    input  logic                  i_rst_n_rt,
    input  logic                  i_start_rt,
    input  logic [DATA_WIDTH-1:0] i_seed_rt,
    input  logic                  i_mode_rt,
    output logic                  o_busy_rt,
    output logic                  o_done_rt,
    output logic                  o_pass_rt,
    output logic [ADDR_WIDTH:0]   o_err_cnt_rt,
    output logic [ADDR_WIDTH-1:0] o_err_addr_rt,
    output logic [ADDR_WIDTH-1:0] o_addr_rt,
    output logic [DATA_WIDTH-1:0] o_wdata_rt,
    output logic                  o_en_rt,
    output logic                  o_we_rt,
    output logic                  o_re_rt,
    input  logic [DATA_WIDTH-1:0] i_rdata_rt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_K  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    // Compare pipeline: expected word/address trail the read request by one cycle.
    logic                  chk_vld_q, chk_vld_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;

    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] k_next;

    function automatic logic [DATA_WIDTH-1:0] pat_at(
        input logic [DATA_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0] k,
        input logic                  m
    );
        return DATA_WIDTH'(pattern(PAT_W'(s), PAT_W'(k), m));
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        seed_d     = seed_q;
        mode_d     = mode_q;
        wdata_d    = '0;
        en_d       = 1'b0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        chk_vld_d  = 1'b0;
        exp_d      = '0;
        exp_addr_d = '0;
        k_next     = k_q + 1'b1;
        mismatch   = chk_vld_q && (i_rdata_rt != exp_q);

        if (mismatch) begin
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
                err_addr_d = exp_addr_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_start_rt) begin
                    seed_d     = i_seed_rt;
                    mode_d     = i_mode_rt;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    pass_d     = 1'b0;
                    k_d        = '0;
                    state_d    = StWrite;
                    busy_d     = 1'b1;
                    en_d       = 1'b1;
                    we_d       = 1'b1;
                    wdata_d    = pat_at(i_seed_rt, '0, i_mode_rt);
                end
            end
            StWrite: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = StRead;
                    re_d    = 1'b1;
                end else begin
                    k_d     = k_next;
                    we_d    = 1'b1;
                    wdata_d = pat_at(seed_q, k_next, mode_q);
                end
            end
            StRead: begin
                busy_d     = 1'b1;
                chk_vld_d  = 1'b1;
                exp_d      = pat_at(seed_q, k_q, mode_q);
                exp_addr_d = k_q;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d  = k_next;
                    en_d = 1'b1;
                    re_d = 1'b1;
                end
            end
            StDrain: begin
                // The final read word is compared this cycle, so pass uses the updated count.
                state_d = StDone;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == '0);
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk_rt or negedge i_rst_n_rt) begin
        if (!i_rst_n_rt) begin
            state_q    <= StIdle;
            k_q        <= '0;
            seed_q     <= '0;
            mode_q     <= 1'b0;
            wdata_q    <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            chk_vld_q  <= 1'b0;
            exp_q      <= '0;
            exp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            seed_q     <= seed_d;
            mode_q     <= mode_d;
            wdata_q    <= wdata_d;
            en_q       <= en_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            chk_vld_q  <= chk_vld_d;
            exp_q      <= exp_d;
            exp_addr_q <= exp_addr_d;
        end
    end

    assign o_busy_rt     = busy_q;
    assign o_done_rt     = done_q;
    assign o_pass_rt     = pass_q;
    assign o_err_cnt_rt  = err_cnt_q;
    assign o_err_addr_rt = err_addr_q;
    assign o_addr_rt     = k_q;
    assign o_wdata_rt    = wdata_q;
    assign o_en_rt       = en_q;
    assign o_we_rt       = we_q;
    assign o_re_rt       = re_q;

endmodule

// File: tb/tb_ram_tester.sv
// Bench for ram_tester: RAM responder with injectable faults, scoreboard of bus ops and results.
module tb_ram_tester;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          mode = 1'b0;
    logic          busy, done, pass, en, we, re;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] err_addr, addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;

    logic [DW-1:0] mem [D];
    logic [DW-1:0] wr_log [D];
    int            fault = 0;
    int            total = 0;
    int            bad = 0;
    int            done_seen = 0;
    int            busy_cnt = 0;

    typedef struct {logic pass; int cnt; int eaddr;} res_t;
    typedef struct {logic we; int addr; logic [DW-1:0] data;} op_t;
    res_t res_q[$];
    op_t  op_q[$];

    always #5 clk = ~clk;

    ram_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(D)) dut (
        .i_clk_rt      (clk),
        .i_rst_n_rt    (rst_n),
        .i_start_rt    (start),
        .i_seed_rt     (seed),
        .i_mode_rt     (mode),
        .o_busy_rt     (busy),
        .o_done_rt     (done),
        .o_pass_rt     (pass),
        .o_err_cnt_rt  (err_cnt),
        .o_err_addr_rt (err_addr),
        .o_addr_rt     (addr),
        .o_wdata_rt    (wdata),
        .o_en_rt       (en),
        .o_we_rt       (we),
        .o_re_rt       (re),
        .i_rdata_rt    (rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int k, input logic m);
        logic [DW-1:0] v;
        v = DW'(int'(s) + k);
        return m ? ~v : v;
    endfunction

    // Fault 1: bit 3 of address 5 stuck at 0. Fault 2: data lines stuck at 0.
    function automatic logic [DW-1:0] faulty(input int f, input int a, input logic [DW-1:0] d);
        if (f == 1 && a == 5) return d & 8'hF7;
        if (f == 2) return '0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
        if (en && re) rdata <= faulty(fault, int'(addr), mem[addr]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [DW-1:0] s, input logic m, input int f);
        res_t r;
        r.pass = 1'b1;
        r.cnt = 0;
        r.eaddr = 0;
        for (int k = 0; k < D; k++) op_q.push_back('{1'b1, k, pat(s, k, m)});
        for (int k = 0; k < D; k++) begin
            op_q.push_back('{1'b0, k, '0});
            if (faulty(f, k, pat(s, k, m)) != pat(s, k, m)) begin
                if (r.cnt == 0) r.eaddr = k;
                r.cnt++;
            end
        end
        r.pass = (r.cnt == 0);
        res_q.push_back(r);
    endtask

    // Monitor: bus-protocol checks and scoreboard pops, sampled on the falling edge.
    initial begin
        op_t  o;
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                check("we_re_excl", {63'd0, we && re}, 64'd0);
                check("en_eq_we_or_re", {63'd0, en}, {63'd0, we || re});
                if (we || re) begin
                    if (op_q.size() == 0) begin
                        check("unexpected_op", 64'(op_q.size()), 64'd1);
                    end else begin
                        o = op_q.pop_front();
                        check("op_kind", {63'd0, we}, {63'd0, o.we});
                        check("op_addr", 64'(addr), 64'(o.addr));
                        if (o.we) begin
                            check("op_wdata", 64'(wdata), 64'(o.data));
                            wr_log[addr] = wdata;
                        end
                    end
                end
                if (busy) busy_cnt++;
                if (done) begin
                    done_seen++;
                    check("busy_cycles", 64'(busy_cnt), 64'(2 * D + 1));
                    check("busy_in_done", {63'd0, busy}, 64'd0);
                    check("ops_consumed", 64'(op_q.size()), 64'd0);
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 64'(res_q.size()), 64'd1);
                    end else begin
                        r = res_q.pop_front();
                        check("pass", {63'd0, pass}, {63'd0, r.pass});
                        check("err_cnt", 64'(err_cnt), 64'(r.cnt));
                        check("err_addr", 64'(err_addr), 64'(r.eaddr));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {63'd0, n < 200}, 64'd1);
    endtask

    task automatic start_run(input logic [DW-1:0] s, input logic m, input int f);
        wait_idle();
        fault = f;
        seed = s;
        mode = m;
        start = 1'b1;
        push_run(s, m, f);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle, plus 1 time unit.
    task automatic wait_done();
        int d0 = done_seen;
        int n = 0;
        while (done_seen == d0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", {63'd0, done_seen != d0}, 64'd1);
    endtask

    initial begin
        int d0;
        int glitch;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_pass", {63'd0, pass}, 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        check("rst_bus", {59'd0, en, we, re, 1'b0, 1'b0}, 64'd0);
        check("rst_addr_wdata", {52'd0, addr, wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_run(8'h00, 1'b0, 0);
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_pass", {63'd0, pass}, 64'd1);
        check("hold_err_cnt", 64'(err_cnt), 64'd0);
        check("seed0_wdata15", 64'(wr_log[15]), 64'h0F);

        start_run(8'hF8, 1'b1, 0);
        wait_done();
        check("inv_wdata0", 64'(wr_log[0]), 64'h07);
        check("inv_wdata8", 64'(wr_log[8]), 64'hFF);

        start_run(8'h08, 1'b0, 1);
        wait_done();
        start_run(8'h01, 1'b0, 2);
        wait_done();
        check("sat_err_cnt", 64'(err_cnt), 64'd16);

        // Starts during a run and during DONE are ignored.
        start_run(8'h00, 1'b0, 0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        seed = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_seen;
        repeat (50) @(negedge clk);
        check("ignored_done_start", 64'(done_seen), 64'(d0));
        check("ignored_busy", {63'd0, busy}, 64'd0);
        check("unchanged_pass", {63'd0, pass}, 64'd1);

        // Start held high re-triggers one cycle after DONE.
        wait_idle();
        fault = 0;
        seed = 8'h3C;
        mode = 1'b0;
        start = 1'b1;
        push_run(8'h3C, 1'b0, 0);
        wait_done();
        push_run(8'h3C, 1'b0, 0);
        @(negedge clk);
        check("retrig_idle", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("retrig_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        wait_done();

        // Reset during READ abandons the run.
        start_run(8'hA5, 1'b1, 0);
        repeat (19) @(negedge clk);
        check("mid_in_read", {63'd0, re}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_en_drop", {63'd0, en}, 64'd0);
        check("rst_re_drop", {63'd0, re}, 64'd0);
        check("rst_busy_drop", {63'd0, busy}, 64'd0);
        op_q.delete();
        res_q.delete();
        d0 = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 64'(done_seen), 64'(d0));
        start_run(8'h11, 1'b0, 0);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            start_run(DW'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            glitch = int'($urandom_range(1, 2 * D));
            repeat (glitch) @(negedge clk);
            start = 1'b1;
            seed = DW'($urandom);
            mode = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("final_res_q", 64'(res_q.size()), 64'd0);
        check("final_op_q", 64'(op_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
